// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer state encodings and target-second lookup
package timer_pkg;

    localparam logic [2:0] ST_INACTIVE  = 3'd0;
    localparam logic [2:0] ST_ARMED_5   = 3'd1;
    localparam logic [2:0] ST_ARMED_10  = 3'd2;
    localparam logic [2:0] ST_ARMED_15  = 3'd3;
    localparam logic [2:0] ST_ACTIVE_5  = 3'd4;
    localparam logic [2:0] ST_ACTIVE_10 = 3'd5;
    localparam logic [2:0] ST_ACTIVE_15 = 3'd6;
    localparam logic [2:0] ST_COMPLETE  = 3'd7;

    localparam logic [3:0] TARGET_5  = 4'd5;
    localparam logic [3:0] TARGET_10 = 4'd10;
    localparam logic [3:0] TARGET_15 = 4'd15;

    function automatic logic [3:0] target_seconds(input logic [2:0] state);
        case (state)
            ST_ARMED_5,  ST_ACTIVE_5:  return TARGET_5;
            ST_ARMED_10, ST_ACTIVE_10: return TARGET_10;
            ST_ARMED_15, ST_ACTIVE_15: return TARGET_15;
            ST_INACTIVE, ST_COMPLETE:  return 4'd0;
            default:                   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic enable,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = enable && (count == LAST);

    // Disabling holds the divider at zero so every new run gets a full first period.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/timer_second_counter.sv
// rtl/timer_second_counter.sv - elapsed/remaining seconds, tick and alarm for the fan timer FSM
module timer_second_counter
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_timerState,
    output logic [31:0] o_downCount,
    output logic [3:0]  o_remaining,
    output logic        o_tick,
    output logic        o_alarm
);

    logic       running;
    logic       counting;
    logic [3:0] target;

    // Codes 4..7 all have bit 2 set; COMPLETE keeps the divider going for the alarm.
    assign running  = i_timerState[2];
    assign counting = running && (i_timerState != ST_COMPLETE);
    assign target   = target_seconds(i_timerState);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .enable  (running),
        .tick    (o_tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_downCount <= '0;
        end else if (!running) begin
            o_downCount <= '0;
        end else if (counting && o_tick && (o_downCount != 32'hFFFF_FFFF)) begin
            o_downCount <= o_downCount + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_alarm <= 1'b0;
        end else if (i_timerState == ST_COMPLETE) begin
            if (o_tick) begin
                o_alarm <= ~o_alarm;
            end
        end else begin
            o_alarm <= 1'b0;
        end
    end

    always_comb begin
        o_remaining = 4'd0;
        if (counting) begin
            if (o_downCount < {28'd0, target}) begin
                o_remaining = target - o_downCount[3:0];
            end
        end else if (!running) begin
            o_remaining = target;
        end
    end

endmodule

// File: doc/timer_second_counter.md
# timer_second_counter

Seconds-count engine paired with the fan timer state machine. It consumes the 3-bit timer state and produces the elapsed-seconds count that the state machine compares against its 5/10/15 s limits. It also drives a remaining-seconds value for the display path and an alarm toggle for the COMPLETE state. It sits between the timer FSM and the FND/LED output logic, clocked by the board clock.

## Interface
- TICK_DIV, 100_000_000: clock cycles per one-second tick; legal range ≥ 2.
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_timerState  input  3  timer state code from the timer FSM.
- o_downCount  output  32  elapsed whole seconds in the current active run; feeds the FSM count input.
- o_remaining  output  4  seconds left for display, 0..15.
- o_tick  output  1  one-cycle pulse on each one-second boundary.
- o_alarm  output  1  square wave while COMPLETE, toggling once per second.

## Operation
- State codes, all eight legal:
  - 0: INACTIVE.
  - 1, 2, 3: armed at 5, 10 or 15 s.
  - 4, 5, 6: active at 5, 10 or 15 s.
  - 7: COMPLETE.
- Target seconds: 5 for codes 1 and 4; 10 for codes 2 and 5; 15 for codes 3 and 6.
- Prescaler, 0..TICK_DIV-1:
  - Runs only in states 4–7.
  - Held at 0 in states 0–3.
  - On reaching TICK_DIV-1 it wraps to 0 and o_tick is 1 for that cycle.
- o_downCount, registered:
  - States 0–3: cleared to 0.
  - States 4–6: +1 on each cycle o_tick=1; saturates at 32'hFFFF_FFFF with no wrap.
  - State 7: holds its value and ignores ticks.
- Switching directly between active codes (e.g. 4→5) does not clear the count or the prescaler. Only states 0–3 clear them.
- o_remaining, combinational from the state and o_downCount:
  - States 1–3: the target.
  - States 4–6: target − o_downCount, floored at 0.
  - States 0 and 7: 0.
- o_alarm, registered:
  - State 7: toggles on each o_tick.
  - Any other state: forced to 0.
  - The first toggle (0→1) happens one full TICK_DIV period after entering state 7.
- Reset: prescaler=0, o_downCount=0, o_tick=0, o_alarm=0. o_remaining follows the state (0 for state 0).

## Timing
- o_tick is asserted combinationally in the cycle where the prescaler equals TICK_DIV-1 and the state is 4–7.
- o_downCount updates on the same rising edge on which the prescaler wraps.
- The FSM samples the new count on the following edge. Example: count becomes 5 at edge N, so the FSM is in COMPLETE after edge N+1.
- Count remains target after completion: TICK_DIV ≥ 2 ensures no second tick lands before the FSM leaves the active state.
- Entry into an active state from an armed state: first tick exactly TICK_DIV cycles after the first active cycle; the count reaches target after target×TICK_DIV active cycles.
- Reset is asynchronous: all registers clear immediately on assertion, mid-count included. After release, counting restarts from prescaler 0 if the state is active.
- Cancel (active → 0–3) clears the count and prescaler on the next edge. Re-entry then gets a full first second.
- No handshake: the state input is level-sampled every cycle.

## Structure
- Shared package timer_pkg:
  - the eight state encodings, as 3-bit localparams;
  - target-second constants 5, 10 and 15;
  - a function mapping a state code to its target (0 for states 0 and 7).
- The timer FSM and this block both import timer_pkg.
- One natural sub-module: tick_prescaler (parameter TICK_DIV; inputs i_clk, i_reset, enable; output one-cycle tick).
- The count, alarm and remaining logic stay in the top block.

## Test plan
All scenarios use TICK_DIV=4.
- Reset with i_timerState=0: o_downCount=0, o_remaining=0, o_tick=0, o_alarm=0; assert async reset mid-cycle and check outputs clear before the next edge.
- State 1 for 10 cycles, then 4: o_remaining=5 and count 0 while armed; ticks on active cycles 4, 8, 12, 16, 20; count 1..5; o_remaining 4..0.
- Count 5, then drive 7 for 16 cycles, then 0:
  - count holds 5 and o_remaining=0;
  - o_alarm toggles at cycles 4, 8, 12, 16;
  - one cycle after state 0, count=0 and o_alarm=0.
- State 6 for 60 cycles: count=15 and o_remaining=0, with exactly 15 o_tick pulses.
- State 5 until count=3, pulse reset for 1 cycle with state held at 5: count=0 immediately; first tick 4 cycles after release; count=10 after 40 further cycles.
- State 4 until count=2 plus 2 prescaler cycles, drive 1 for 1 cycle, then 4 again: count clears to 0; next tick comes 4 cycles after re-entry, not 2.
